uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter among N_REQ word requesters using round-robin arbitration.
- Accepts one word per grant over a valid/ready handshake and drives the transmitter's data, send-strobe and ready inputs.
- The transmitter has no completion output, so the block times each frame from the baud parameters and then reports per-requester completion.
- Sits between the requesters (command/status sources) and the UART transmit datapath.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz; must match the transmitter.
- BAUD_RATE, 115200, line bit rate; must match the transmitter.
- DATA_WIDTH, 8, bits per word.
- N_REQ, 4, number of requesters; minimum 2.
- SEND_PULSE_CYCLES, 4, clk cycles tx_send_o is held high per frame; range 2 to BAUD_DIV-1.
- Derived: BAUD_DIV = CLK_FREQ/BAUD_RATE.
- Derived: FRAME_CYCLES = BAUD_DIV*(DATA_WIDTH+4). Covers start, data and stop bits, plus 2 bit-times of guard for the transmitter's strobe synchronisation.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid_i  in  N_REQ  per-requester word valid
- req_data_i  in  N_REQ*DATA_WIDTH  flattened words; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- req_ready_o  out  N_REQ  per-requester accept (combinational, one-hot or zero)
- done_o  out  N_REQ  one-cycle pulse when requester's frame time has elapsed
- cts_i  in  1  far-end clear-to-send; new frames launch only while high
- tx_data_o  out  DATA_WIDTH  word to transmitter data input
- tx_send_o  out  1  send strobe to transmitter
- tx_rx_ready_o  out  1  ready input of transmitter
- busy_o  out  1  high outside IDLE
- gnt_id_o  out  $clog2(N_REQ)  index of current/last granted requester

Behaviour:
- Reset (async, active-low):
  - state=IDLE, rr_ptr=0, counter=0.
  - tx_data_o=0, tx_send_o=0, tx_rx_ready_o=0, busy_o=0, gnt_id_o=0, done_o=0, req_ready_o=0.
- States: IDLE, PULSE, WAIT, DONE.
- IDLE:
  - Winner = first i with req_valid_i[i]=1, searching from rr_ptr upward with wrap modulo N_REQ.
  - If any valid and cts_i=1, req_ready_o[winner]=1 combinationally; all other bits 0.
  - If cts_i=0, req_ready_o=0.
  - Handshake edge k (valid&ready) registers: tx_data_o<=req_data_i[winner], gnt_id_o<=winner, counter<=0, tx_send_o<=1, tx_rx_ready_o<=1, busy_o<=1, state<=PULSE.
- PULSE:
  - Counter increments each cycle.
  - tx_send_o falls at edge k+SEND_PULSE_CYCLES; state then becomes WAIT.
- WAIT:
  - Counter keeps incrementing.
  - At edge k+FRAME_CYCLES: tx_rx_ready_o<=0, done_o[gnt_id_o]<=1, state<=DONE.
- DONE (one cycle):
  - done_o deasserts at the next edge.
  - rr_ptr<=(gnt_id_o+1) mod N_REQ; state<=IDLE; busy_o<=0.
- Latency and throughput:
  - Handshake-to-done_o = FRAME_CYCLES cycles.
  - Earliest next handshake is edge k+FRAME_CYCLES+2.
- Register stability: tx_data_o and gnt_id_o are held constant from edge k until the next handshake.
- req_ready_o is 0 in every state except IDLE. Requesters must hold valid and data until accepted; withdrawing valid before acceptance is legal.
- cts_i is sampled only in IDLE. Deassertion during PULSE/WAIT does not abort the frame.
- All requesters valid continuously: grants rotate 0,1,2,...,N_REQ-1,0,...
- Single requester valid continuously: it is granted back-to-back regardless of rr_ptr.
- Counter width is $clog2(FRAME_CYCLES+1); it never wraps within a frame.
- Reset asserted mid-frame:
  - All outputs return to reset values immediately; tx_send_o and tx_rx_ready_o drop asynchronously.
  - The in-flight word is lost, and no done_o is issued for it.

Test Plan:
- Common setup: CLK_FREQ=160, BAUD_RATE=10 (BAUD_DIV=16), DATA_WIDTH=8, N_REQ=4, SEND_PULSE_CYCLES=4, so FRAME_CYCLES=192.
- Single word: req 2 valid with 0xA5, cts_i=1 -> req_ready_o=4'b0100 for 1 cycle; tx_data_o=0xA5; tx_send_o high exactly 4 cycles; done_o=4'b0100 exactly 192 cycles after handshake; serial line carries 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop).
- Fairness: all 4 valid continuously with words 0x10..0x13 -> grant order 0,1,2,3,0; handshakes 194 cycles apart; done_o in the same order.
- Flow control: req 1 valid with cts_i=0 for 50 cycles -> req_ready_o=0, busy_o=0 throughout; cts_i rises -> handshake in the same cycle. cts_i dropped during WAIT -> frame still completes with done_o at 192 cycles.
- Rotation skip: only reqs 0 and 3 valid, rr_ptr=1 -> req 3 granted first, then 0, then 3.
- Reset mid-frame: rst_n low at cycle 100 of WAIT -> tx_send_o=0, tx_rx_ready_o=0, busy_o=0, no done_o; after release, req 0 (rr_ptr=0) wins first.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side word handshake and completion bundle.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 8
);
    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ*DATA_WIDTH-1:0] req_data_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [N_REQ-1:0]            done_o;

    modport master (
        output req_valid_i,
        output req_data_i,
        input  req_ready_o,
        input  done_o
    );

    modport slave (
        input  req_valid_i,
        input  req_data_i,
        output req_ready_o,
        output done_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one UART transmitter, frame-timed completion.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int CLK_FREQ          = 100_000_000,
    parameter int BAUD_RATE         = 115200,
    parameter int DATA_WIDTH        = 8,
    parameter int N_REQ             = 4,
    parameter int SEND_PULSE_CYCLES = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst_n,
    uart_tx_arbiter_if.slave              req,
    input  wire logic                     cts_i,
    output logic [DATA_WIDTH-1:0]         tx_data_o,
    output logic                          tx_send_o,
    output logic                          tx_rx_ready_o,
    output logic                          busy_o,
    output logic [$clog2(N_REQ)-1:0]      gnt_id_o
);
    localparam int c_BAUD_DIV     = CLK_FREQ / BAUD_RATE;
    localparam int c_FRAME_CYCLES = c_BAUD_DIV * (DATA_WIDTH + 4);
    localparam int c_CNT_W        = $clog2(c_FRAME_CYCLES + 1);
    localparam int c_ID_W         = $clog2(N_REQ);

    localparam logic [c_CNT_W-1:0] c_PULSE_LAST = c_CNT_W'(SEND_PULSE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_FRAME_LAST = c_CNT_W'(c_FRAME_CYCLES - 1);
    localparam logic [c_ID_W-1:0]  c_LAST_ID    = c_ID_W'(N_REQ - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_PULSE = 2'd1;
    localparam logic [1:0] c_S_WAIT  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_ID_W-1:0]     r_rr_ptr;
    logic [N_REQ-1:0]      r_done;
    logic [N_REQ-1:0]      w_req_ready;
    logic [c_ID_W-1:0]     w_winner;
    logic [c_ID_W-1:0]     w_cand;
    logic                  w_found;
    logic                  w_hs;
    logic [DATA_WIDTH-1:0] w_words [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign w_words[g] = req.req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // First valid requester at or after the rotation pointer, wrapping.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int j = 0; j < N_REQ; j++) begin
            w_cand = c_ID_W'((int'(r_rr_ptr) + j) % N_REQ);
            if (!w_found && req.req_valid_i[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE:  if (w_hs) w_state_next = c_S_PULSE;
            c_S_PULSE: if (r_cnt == c_PULSE_LAST) w_state_next = c_S_WAIT;
            c_S_WAIT:  if (r_cnt == c_FRAME_LAST) w_state_next = c_S_DONE;
            c_S_DONE:  w_state_next = c_S_IDLE;
            default:   w_state_next = c_S_IDLE;
        endcase
    end

    // Ready is gated by rst_n so it reads zero for the whole reset window.
    always_comb begin
        w_hs        = rst_n && cts_i && w_found && (r_state == c_S_IDLE);
        w_req_ready = '0;
        if (w_hs) w_req_ready[w_winner] = 1'b1;
        busy_o      = (r_state != c_S_IDLE);
    end

    assign req.req_ready_o = w_req_ready;
    assign req.done_o      = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data_o     <= '0;
            gnt_id_o      <= '0;
            tx_send_o     <= 1'b0;
            tx_rx_ready_o <= 1'b0;
            r_cnt         <= '0;
            r_rr_ptr      <= '0;
            r_done        <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_hs) begin
                        tx_data_o     <= w_words[w_winner];
                        gnt_id_o      <= w_winner;
                        r_cnt         <= '0;
                        tx_send_o     <= 1'b1;
                        tx_rx_ready_o <= 1'b1;
                    end
                end
                c_S_PULSE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_PULSE_LAST) tx_send_o <= 1'b0;
                end
                c_S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == c_FRAME_LAST) begin
                        tx_rx_ready_o    <= 1'b0;
                        r_done[gnt_id_o] <= 1'b1;
                    end
                end
                c_S_DONE: begin
                    r_rr_ptr <= (gnt_id_o == c_LAST_ID) ? '0 : gnt_id_o + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed bench with a frame-timing reference model for uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N     = 4;
    localparam int DW    = 8;
    localparam int SPC   = 4;
    localparam int FRAME = 192;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic cts   = 1'b0;
    logic [DW-1:0] tx_data;
    logic tx_send, tx_rdy, busy;
    logic [1:0] gnt;

    uart_tx_arbiter_if #(.N_REQ(N), .DATA_WIDTH(DW)) bus ();

    uart_tx_arbiter #(
        .CLK_FREQ(160), .BAUD_RATE(10), .DATA_WIDTH(DW),
        .N_REQ(N), .SEND_PULSE_CYCLES(SPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .req(bus), .cts_i(cts),
        .tx_data_o(tx_data), .tx_send_o(tx_send), .tx_rx_ready_o(tx_rdy),
        .busy_o(busy), .gnt_id_o(gnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] v, input int rr);
        for (int j = 0; j < N; j++) begin
            int idx;
            idx = (rr + j) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Reference model: a frame is just "edges elapsed since the handshake".
    bit            m_active = 1'b0;
    int            m_e      = 0;
    int            m_rr     = 0;
    int            m_gnt    = 0;
    logic [DW-1:0] m_data   = '0;
    int            exp_win;

    always_comb exp_win = pick(bus.req_valid_i, m_rr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active <= 1'b0; m_e <= 0; m_rr <= 0; m_gnt <= 0; m_data <= '0;
        end else if (m_active) begin
            m_e <= m_e + 1;
            if (m_e + 1 == FRAME + 1) begin
                m_active <= 1'b0;
                m_rr     <= (m_gnt + 1) % N;
            end
        end else if (cts && exp_win >= 0) begin
            m_active <= 1'b1;
            m_e      <= 0;
            m_gnt    <= exp_win;
            m_data   <= bus.req_data_i[exp_win*DW +: DW];
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        logic [N-1:0] e_ready, e_done;
        e_ready = (rst_n && !m_active && cts && exp_win >= 0) ? N'(1 << exp_win) : '0;
        e_done  = (m_active && m_e == FRAME) ? N'(1 << m_gnt) : '0;
        chk("req_ready", 32'(bus.req_ready_o), 32'(e_ready));
        chk("done",      32'(bus.done_o),      32'(e_done));
        chk("tx_send",   32'(tx_send), 32'(m_active && m_e < SPC));
        chk("tx_rx_rdy", 32'(tx_rdy),  32'(m_active && m_e < FRAME));
        chk("busy",      32'(busy),    32'(m_active));
        chk("tx_data",   32'(tx_data), 32'(m_data));
        chk("gnt_id",    32'(gnt),     32'(m_gnt));
    end

    // Event log used by the hand-computed checks.
    int hs_cyc[$], hs_id[$], dn_cyc[$], dn_id[$], dn_send[$];
    int send_cnt = 0;

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    always @(negedge clk) begin
        if (tx_send) send_cnt <= send_cnt + 1;
        if (|(bus.req_ready_o & bus.req_valid_i)) begin
            hs_cyc.push_back(cyc + 1);
            hs_id.push_back(oh_idx(bus.req_ready_o));
            send_cnt <= 0;
        end
        if (|bus.done_o) begin
            dn_cyc.push_back(cyc);
            dn_id.push_back(oh_idx(bus.done_o));
            dn_send.push_back(send_cnt);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic wait_hs(input int target, input int bound);
        int i = 0;
        while (hs_cyc.size() < target && i < bound) begin
            tick(1);
            i++;
        end
        chk("hs_count", 32'(hs_cyc.size()), 32'(target));
    endtask

    task automatic wait_idle(input int bound);
        int i = 0;
        while (busy && i < bound) begin
            tick(1);
            i++;
        end
        chk("idle_reached", 32'(busy), 32'd0);
        tick(1);
    endtask

    initial begin
        int hb, db;
        int order5 [5] = '{0, 1, 2, 3, 0};
        int order3 [3] = '{3, 0, 3};
        int ser    [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
        logic [9:0] line;

        bus.req_valid_i = '0;
        bus.req_data_i  = '0;
        #1 rst_n = 1'b0;
        tick(3);
        bus.req_valid_i = 4'hF;
        cts = 1'b1;
        #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_data",  32'(tx_data), 32'd0);
        bus.req_valid_i = '0;
        rst_n = 1'b1;
        tick(2);

        // Fairness: all valid from rr_ptr=0
        hb = hs_cyc.size(); db = dn_cyc.size();
        bus.req_data_i  = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_valid_i = 4'hF;
        wait_hs(hb + 5, 5 * 200);
        bus.req_valid_i = '0;
        wait_idle(300);
        for (int i = 0; i < 5; i++) begin
            chk("fair_gnt",  32'(hs_id[hb+i]), 32'(order5[i]));
            chk("fair_done", 32'(dn_id[db+i]), 32'(order5[i]));
            chk("fair_lat",  32'(dn_cyc[db+i] - hs_cyc[hb+i]), 32'd192);
            chk("fair_send", 32'(dn_send[db+i]), 32'd4);
            if (i > 0) chk("fair_gap", 32'(hs_cyc[hb+i] - hs_cyc[hb+i-1]), 32'd194);
        end

        // Rotation skip: only 0 and 3 valid, rr_ptr now 1
        hb = hs_cyc.size();
        bus.req_valid_i = 4'b1001;
        wait_hs(hb + 3, 3 * 200);
        bus.req_valid_i = '0;
        wait_idle(300);
        for (int i = 0; i < 3; i++) chk("rot_gnt", 32'(hs_id[hb+i]), 32'(order3[i]));

        // Single word from requester 2
        db = dn_cyc.size();
        bus.req_data_i  = 32'h00A5_0000;
        bus.req_valid_i = 4'b0100;
        #1 chk("single_ready", 32'(bus.req_ready_o), 32'b0100);
        tick(1);
        bus.req_valid_i = '0;
        #1;
        chk("single_ready_off", 32'(bus.req_ready_o), 32'd0);
        chk("single_data", 32'(tx_data), 32'hA5);
        line = {1'b1, tx_data, 1'b0};
        for (int i = 0; i < 10; i++) chk("serial_bit", 32'(line[i]), 32'(ser[i]));
        wait_idle(300);
        chk("single_done_id", 32'(dn_id[db]), 32'd2);
        chk("single_lat", 32'(dn_cyc[db] - hs_cyc[hs_cyc.size()-1]), 32'd192);
        chk("single_send", 32'(dn_send[db]), 32'd4);

        // Flow control on requester 1
        bus.req_data_i  = 32'h0000_5C00;
        bus.req_valid_i = 4'b0010;
        cts = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            chk("cts_ready", 32'(bus.req_ready_o), 32'd0);
            chk("cts_busy",  32'(busy), 32'd0);
        end
        cts = 1'b1;
        #1 chk("cts_rise_ready", 32'(bus.req_ready_o), 32'b0010);
        db = dn_cyc.size();
        tick(1);
        bus.req_valid_i = '0;
        tick(30);
        cts = 1'b0;
        wait_idle(300);
        chk("cts_done_id", 32'(dn_id[db]), 32'd1);
        chk("cts_lat", 32'(dn_cyc[db] - hs_cyc[hs_cyc.size()-1]), 32'd192);
        cts = 1'b1;

        // Reset mid-frame on requester 2
        bus.req_data_i  = 32'h003C_0000;
        bus.req_valid_i = 4'b0100;
        tick(1);
        bus.req_valid_i = '0;
        tick(SPC + 99);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        db = dn_cyc.size();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_send", 32'(tx_send), 32'd0);
        chk("mid_rst_rdy",  32'(tx_rdy), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        chk("mid_rst_nodone", 32'(dn_cyc.size()), 32'(db));
        bus.req_valid_i = 4'hF;
        #1 chk("post_rst_ready", 32'(bus.req_ready_o), 32'b0001);
        tick(1);
        bus.req_valid_i = '0;
        wait_idle(300);
        chk("post_rst_done", 32'(dn_id[dn_id.size()-1]), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
